log_event_capture: RTL
======================

LOG_EVENT_CAPTURE -- requirements
Module: log_event_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter CODE_W, default 16, event code width.
REQ-003 SHALL have parameter CNT_W, default 16, width of each statistics counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have port ev_valid, input, 1, event offered this cycle.
REQ-007 SHALL have port ev_sev, input, 2, severity: 0 INFO, 1 INFO_PASS, 2 WARNING, 3 ERROR.
REQ-008 SHALL have port ev_code, input, CODE_W, event identifier.
REQ-009 SHALL have port out_valid / out_ready, output / input, 1 each, output stream handshake.
REQ-010 SHALL have port out_sev / out_code / out_ts, output, 2 / CODE_W / 32, buffered record.
REQ-011 SHALL have port info_cnt / warning_cnt / error_cnt / drop_cnt, output, CNT_W each, statistics.
REQ-012 SHALL have port clear_cnt, input, 1, synchronous clear of the statistics counters.
REQ-013 SHALL have port error_seen, output, 1, sticky flag set by any ERROR event.

Function
REQ-014 SHALL run a free-running 32-bit cycle counter that increments every cycle, wraps from 0xFFFF_FFFF to 0, and restarts from 0 after reset.
REQ-015 SHALL accept an event on a cycle with ev_valid=1 when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-016 SHALL store each accepted event as {sev, code, ts}, where ts is the cycle-counter value in the acceptance cycle.
REQ-017 SHALL have no ingress backpressure: an event that cannot be accepted is dropped, and drop_cnt increments.
REQ-018 SHALL pop on out_valid and out_ready both 1; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 SHALL raise out_valid in cycle N+1 for an event accepted into an empty FIFO in cycle N; there is no same-cycle bypass.
REQ-020 SHALL keep FIFO order strict; read and write pointers wrap modulo DEPTH, and full/empty are distinguished by an extra pointer bit.
REQ-021 SHALL handle simultaneous push and pop on a non-empty FIFO with the occupancy unchanged.
REQ-022 SHALL handle a pop on an empty FIFO as a no-op (out_valid=0).
REQ-023 SHALL increment info_cnt for INFO and INFO_PASS, warning_cnt for WARNING, and error_cnt for ERROR on every offered event, including dropped events.
REQ-024 SHALL saturate all counters at all-ones and never wrap.
REQ-025 SHALL give clear_cnt=1 priority: it zeroes the four counters and error_seen, and any event in the same cycle is not counted, although it is still buffered if space allows.
REQ-026 SHALL set error_seen in the cycle after an ERROR event is offered, and hold it until reset or clear_cnt.

Reset
REQ-027 SHALL, with rst_n=0 on a clock edge, empty the FIFO, zero the pointers, the cycle counter, all counters and error_seen, and drive out_valid=0.
REQ-028 SHALL discard buffered records and ignore input events during a reset asserted mid-operation.
REQ-029 SHALL accept an event in the first cycle with rst_n=1; out_sev, out_code and out_ts SHALL read 0 while empty after reset.

Configuration
REQ-030 SHALL, with macro LOG_EVENT_TIMESTAMP_EN defined, implement the cycle counter and store 32-bit timestamps.
REQ-031 SHALL, without LOG_EVENT_TIMESTAMP_EN, omit the counter and timestamp storage and tie out_ts to 0; all other behaviour is unchanged.

Structure
REQ-032 SHALL take from shared package log_event_pkg: the severity enum (SEV_INFO, SEV_INFO_PASS, SEV_WARNING, SEV_ERROR), the record struct typedef, and TS_W=32.
REQ-033 SHALL place the storage array and pointers in sub-module log_event_fifo, parameterised by DEPTH and record type; counters and timestamping stay in the top.

Verification
REQ-034 SHALL cover: reset, then ERROR code 0x00AA at cycle 5 with out_ready=1 -> out_valid in cycle 6 with out_sev=3, out_code=0x00AA, out_ts=5; error_cnt=1; error_seen=1.
REQ-035 SHALL cover: out_ready=0 with 17 INFO events, DEPTH=16 -> 16 records buffered, drop_cnt=1, info_cnt=17; then drain -> codes emerge in order.
REQ-036 SHALL cover: FIFO full with a push and pop in the same cycle -> no drop, occupancy stays 16.
REQ-037 SHALL cover: CNT_W=4 with 20 WARNING events -> warning_cnt=15 (saturated); clear_cnt together with a WARNING event -> warning_cnt=0 next cycle.
REQ-038 SHALL cover: rst_n=0 for 1 cycle with 5 records buffered -> out_valid=0 next cycle, counters 0; a build without LOG_EVENT_TIMESTAMP_EN -> out_ts always 0.

Source files
------------

// File: rtl/log_event_pkg.sv
// Shared types for the event-capture block: severity encoding, the buffered
// record layout and the timestamp width.
package log_event_pkg;

  localparam int TS_W       = 32;
  // Record code field is sized for the widest supported event code; narrower
  // codes are zero-extended on write and truncated on read.
  localparam int CODE_MAX_W = 32;

  typedef enum logic [1:0] {
    SEV_INFO      = 2'd0,
    SEV_INFO_PASS = 2'd1,
    SEV_WARNING   = 2'd2,
    SEV_ERROR     = 2'd3
  } sev_e;

  typedef struct packed {
    sev_e                  sev;
    logic [CODE_MAX_W-1:0] code;
    logic [TS_W-1:0]       ts;
  } log_rec_t;

endpackage

// File: rtl/log_event_fifo.sv
// Record FIFO: DEPTH entries, pointers carry one extra wrap bit so full and
// empty are told apart. Caller only asserts pop when non-empty and push when
// not full or popping in the same cycle. Read data is zero while empty.
module log_event_fifo
  import log_event_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type rec_t = log_rec_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  rec_t wr_data,
  output rec_t rd_data,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  rec_t        mem_q [DEPTH];
  rec_t        mem_d [DEPTH];

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = empty ? rec_t'('0) : mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values and the storage write for this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointers are reset; storage is not (stale entries are unreachable).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage update.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/log_event_capture.sv
// Event capture: timestamps offered events, buffers them in a FIFO with no
// ingress backpressure (overflow drops and counts), and keeps saturating
// per-severity statistics plus a sticky error flag.
// Optional feature macro: LOG_EVENT_TIMESTAMP_EN enables the 32-bit cycle
// counter and timestamp capture; without it out_ts reads 0.
// CODE_W must not exceed log_event_pkg::CODE_MAX_W.
module log_event_capture
  import log_event_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CODE_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ev_valid,
  input  logic [1:0]        ev_sev,
  input  logic [CODE_W-1:0] ev_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_sev,
  output logic [CODE_W-1:0] out_code,
  output logic [TS_W-1:0]   out_ts,
  output logic [CNT_W-1:0]  info_cnt,
  output logic [CNT_W-1:0]  warning_cnt,
  output logic [CNT_W-1:0]  error_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  input  logic              clear_cnt,
  output logic              error_seen
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic            fifo_empty, fifo_full;
  logic            push, pop;
  logic [TS_W-1:0] cur_ts;
  log_rec_t        wr_rec, rd_rec;

  logic [CNT_W-1:0] info_cnt_q, info_cnt_d;
  logic [CNT_W-1:0] warning_cnt_q, warning_cnt_d;
  logic [CNT_W-1:0] error_cnt_q, error_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             error_seen_q, error_seen_d;

`ifdef LOG_EVENT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  // Free-running cycle counter, wraps naturally.
  always_comb begin
    ts_d = ts_q + TS_W'(1);
  end

  // Cycle counter register, restarts from 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_d;
  end

  assign cur_ts = ts_q;
`else
  // No timestamping: the ts field is constant zero and folds away.
  assign cur_ts = '0;
`endif

  // Handshake: a full FIFO still accepts when it pops in the same cycle.
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = ev_valid && (!fifo_full || pop);

  assign wr_rec = '{sev: sev_e'(ev_sev), code: CODE_MAX_W'(ev_code), ts: cur_ts};

  log_event_fifo #(
    .DEPTH (DEPTH),
    .rec_t (log_rec_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_rec),
    .rd_data (rd_rec),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign out_sev  = rd_rec.sev;
  assign out_code = CODE_W'(rd_rec.code);
  assign out_ts   = rd_rec.ts;

  // Statistics: clear wins over counting; every offered event is counted,
  // dropped ones additionally bump drop_cnt.
  always_comb begin
    info_cnt_d    = info_cnt_q;
    warning_cnt_d = warning_cnt_q;
    error_cnt_d   = error_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    error_seen_d  = error_seen_q;
    if (clear_cnt) begin
      info_cnt_d    = '0;
      warning_cnt_d = '0;
      error_cnt_d   = '0;
      drop_cnt_d    = '0;
      error_seen_d  = 1'b0;
    end else if (ev_valid) begin
      case (sev_e'(ev_sev))
        SEV_INFO, SEV_INFO_PASS: info_cnt_d    = sat_inc(info_cnt_q);
        SEV_WARNING:             warning_cnt_d = sat_inc(warning_cnt_q);
        default: begin
          error_cnt_d  = sat_inc(error_cnt_q);
          error_seen_d = 1'b1;
        end
      endcase
      if (!push) drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      info_cnt_q    <= '0;
      warning_cnt_q <= '0;
      error_cnt_q   <= '0;
      drop_cnt_q    <= '0;
      error_seen_q  <= 1'b0;
    end else begin
      info_cnt_q    <= info_cnt_d;
      warning_cnt_q <= warning_cnt_d;
      error_cnt_q   <= error_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      error_seen_q  <= error_seen_d;
    end
  end

  assign info_cnt    = info_cnt_q;
  assign warning_cnt = warning_cnt_q;
  assign error_cnt   = error_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign error_seen  = error_seen_q;

endmodule
